receptor_serial_8n1: RTL and testbench

//  UART receiver, asynchronous serial to parallel. Runs in front of the gate (comporta) controller.

---
 rtl/receptor_serial_8n1.sv | 207 ++++++++++++++++++++
 tb/tb_receptor_serial_8n1.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/receptor_serial_8n1.sv
// receptor_serial_8n1 -- UART receiver (8N1, or 8E1 with RX_PARIDADE_EN).
// Samples the serial line through a 2-FF synchronizer and assembles one byte
// per frame, LSB first. The byte is presented on dado with a one-cycle pronto
// strobe, which the control unit reads as fimRecepcao.
//
// Optional feature: define RX_PARIDADE_EN to receive 8E1 frames (even parity)
// and report parity mismatches on erro_paridade. Undefined: 8N1 frames and
// erro_paridade tied to 0.
//
// Ports:
//   clock          in   1  system clock, rising edge
//   reset          in   1  asynchronous active-low reset
//   entrada_serial in   1  RX line, idle high
//   dado           out  8  last correctly framed byte (held between frames)
//   pronto         out  1  one-cycle pulse when dado is updated
//   erro_stop      out  1  one-cycle pulse when the stop bit is sampled 0
//   erro_paridade  out  1  one-cycle pulse with pronto on parity mismatch
//   dbEstado       out  4  current FSM state code (debug)
module receptor_serial_8n1 #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115_200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic [7:0] dado,
  output logic       pronto,
  output logic       erro_stop,
  output logic       erro_paridade,
  output logic [3:0] dbEstado
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);

  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [3:0] {
    OCIOSO      = 4'd0,
    INICIO      = 4'd1,
    DADOS       = 4'd2,
    PARIDADE    = 4'd3,
    PARADA      = 4'd4,
    PRONTO      = 4'd5,
    ERRO        = 4'd6,
    ESPERA_ALTO = 4'd7
  } estado_t;

  estado_t          estado, estadoNxt;
  logic [CNT_W-1:0] cnt, cntNxt;
  logic [2:0]       bitIdx, bitIdxNxt;
  logic [7:0]       shift, shiftNxt;
  logic [7:0]       dadoNxt;
  logic             prontoNxt;
  logic             erroStopNxt;

  logic rxMeta, rxS, rxPrev;

  // Synchronizer and edge-detect history reset to the idle (high) level so a
  // line that is already low after reset is not mistaken for a start edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
      rxPrev <= 1'b1;
    end else begin
      rxMeta <= entrada_serial;
      rxS    <= rxMeta;
      rxPrev <= rxS;
    end
  end

`ifdef RX_PARIDADE_EN
  logic parFlag, parFlagNxt;
  logic parErrNxt;
`endif

  always_comb begin
    estadoNxt   = estado;
    cntNxt      = cnt;
    bitIdxNxt   = bitIdx;
    shiftNxt    = shift;
    dadoNxt     = dado;
    prontoNxt   = 1'b0;
    erroStopNxt = 1'b0;
`ifdef RX_PARIDADE_EN
    parFlagNxt  = parFlag;
    parErrNxt   = 1'b0;
`endif
    case (estado)
      OCIOSO: begin
        if (rxPrev && !rxS) begin
          estadoNxt = INICIO;
          cntNxt    = '0;
        end
      end
      INICIO: begin
        if (cnt == HALF_LAST) begin
          if (rxS) begin
            estadoNxt = OCIOSO;
          end else begin
            cntNxt    = '0;
            bitIdxNxt = '0;
            estadoNxt = DADOS;
          end
        end else begin
          cntNxt = cnt + 1'b1;
        end
      end
      DADOS: begin
        if (cnt == FULL_LAST) begin
          shiftNxt[bitIdx] = rxS;
          cntNxt           = '0;
          bitIdxNxt        = bitIdx + 3'd1;
          if (bitIdx == 3'd7) begin
`ifdef RX_PARIDADE_EN
            estadoNxt = PARIDADE;
`else
            estadoNxt = PARADA;
`endif
          end
        end else begin
          cntNxt = cnt + 1'b1;
        end
      end
`ifdef RX_PARIDADE_EN
      PARIDADE: begin
        if (cnt == FULL_LAST) begin
          // Even parity: flag is set when data XOR parity bit is odd.
          parFlagNxt = (^shift) ^ rxS;
          cntNxt     = '0;
          estadoNxt  = PARADA;
        end else begin
          cntNxt = cnt + 1'b1;
        end
      end
`endif
      PARADA: begin
        if (cnt == FULL_LAST) begin
          cntNxt    = '0;
          estadoNxt = rxS ? PRONTO : ERRO;
        end else begin
          cntNxt = cnt + 1'b1;
        end
      end
      PRONTO: begin
        dadoNxt   = shift;
        prontoNxt = 1'b1;
`ifdef RX_PARIDADE_EN
        parErrNxt = parFlag;
`endif
        estadoNxt = OCIOSO;
      end
      ERRO: begin
        erroStopNxt = 1'b1;
        estadoNxt   = ESPERA_ALTO;
      end
      ESPERA_ALTO: begin
        if (rxS) begin
          estadoNxt = OCIOSO;
        end
      end
      default: begin
        estadoNxt = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= OCIOSO;
      cnt       <= '0;
      bitIdx    <= '0;
      shift     <= '0;
      dado      <= '0;
      pronto    <= 1'b0;
      erro_stop <= 1'b0;
    end else begin
      estado    <= estadoNxt;
      cnt       <= cntNxt;
      bitIdx    <= bitIdxNxt;
      shift     <= shiftNxt;
      dado      <= dadoNxt;
      pronto    <= prontoNxt;
      erro_stop <= erroStopNxt;
    end
  end

`ifdef RX_PARIDADE_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      parFlag       <= 1'b0;
      erro_paridade <= 1'b0;
    end else begin
      parFlag       <= parFlagNxt;
      erro_paridade <= parErrNxt;
    end
  end
`else
  assign erro_paridade = 1'b0;
`endif

  assign dbEstado = estado;

endmodule

// File: tb/tb_receptor_serial_8n1.sv
// Directed testbench for receptor_serial_8n1 at default parameters
// (50 MHz clock, 115200 baud -> 434 clocks per bit).
module tb_receptor_serial_8n1;

  localparam int CPB = 434;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] dado;
  logic       pronto;
  logic       erro_stop;
  logic       erro_paridade;
  logic [3:0] dbEstado;

  int checks = 0;
  int errors = 0;

  int prontoCnt = 0;
  int erroCnt   = 0;
  int parCnt    = 0;
  logic [7:0] rxQ[$];

  receptor_serial_8n1 dut (
    .clock          (clk),
    .reset          (rst_n),
    .entrada_serial (rx),
    .dado           (dado),
    .pronto         (pronto),
    .erro_stop      (erro_stop),
    .erro_paridade  (erro_paridade),
    .dbEstado       (dbEstado)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Event log sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pronto) begin
        prontoCnt = prontoCnt + 1;
        rxQ.push_back(dado);
      end
      if (erro_stop)     erroCnt = erroCnt + 1;
      if (erro_paridade) parCnt  = parCnt + 1;
    end
  end

  task automatic driveBit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic parBit, input logic stopBit);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(b[i]);
`ifdef RX_PARIDADE_EN
    driveBit(parBit);
`else
    if (parBit === 1'bx) $display("unexpected x parity argument");
`endif
    driveBit(stopBit);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (dado !== 8'h00) begin errors++; $display("FAIL reset_dado got %h expected 00", dado); end
    checks++; if (pronto !== 1'b0) begin errors++; $display("FAIL reset_pronto got %b expected 0", pronto); end
    checks++; if (erro_stop !== 1'b0) begin errors++; $display("FAIL reset_erro_stop got %b expected 0", erro_stop); end
    checks++; if (erro_paridade !== 1'b0) begin errors++; $display("FAIL reset_erro_paridade got %b expected 0", erro_paridade); end
    checks++; if (dbEstado !== 4'h0) begin errors++; $display("FAIL reset_dbEstado got %h expected 0", dbEstado); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(10);
  endtask

  task automatic test_frame_55;
    int p0, e0, q0;
    p0 = prontoCnt; e0 = erroCnt; q0 = rxQ.size();
    @(posedge clk); #1;
    sendFrame(8'h55, 1'b0, 1'b1);
    idle(20);
    checks++; if (prontoCnt - p0 !== 1) begin errors++; $display("FAIL f55_pronto_count got %0d expected 1", prontoCnt - p0); end
    checks++; if (rxQ.size() > q0 && rxQ[q0] !== 8'h55) begin errors++; $display("FAIL f55_byte got %h expected 55", rxQ[q0]); end
    checks++; if (dado !== 8'h55) begin errors++; $display("FAIL f55_dado got %h expected 55", dado); end
    checks++; if (erroCnt - e0 !== 0) begin errors++; $display("FAIL f55_erro_stop got %0d expected 0", erroCnt - e0); end
    checks++; if (dbEstado !== 4'h0) begin errors++; $display("FAIL f55_dbEstado got %h expected 0", dbEstado); end
  endtask

  task automatic test_glitch;
    int p0, e0;
    p0 = prontoCnt; e0 = erroCnt;
    rx = 1'b0;
    repeat (50) @(posedge clk); #1;
    checks++; if (dbEstado !== 4'h1) begin errors++; $display("FAIL glitch_inicio got %h expected 1", dbEstado); end
    repeat (50) @(posedge clk); #1;
    idle(400);
    checks++; if (prontoCnt - p0 !== 0) begin errors++; $display("FAIL glitch_pronto got %0d expected 0", prontoCnt - p0); end
    checks++; if (erroCnt - e0 !== 0) begin errors++; $display("FAIL glitch_erro_stop got %0d expected 0", erroCnt - e0); end
    checks++; if (dbEstado !== 4'h0) begin errors++; $display("FAIL glitch_dbEstado got %h expected 0", dbEstado); end
  endtask

  task automatic test_stop_error;
    int p0, e0;
    p0 = prontoCnt; e0 = erroCnt;
    // 0xA3 has four ones -> even parity bit 0
    sendFrame(8'hA3, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (2000) @(posedge clk); #1;
    checks++; if (erroCnt - e0 !== 1) begin errors++; $display("FAIL stoperr_count got %0d expected 1", erroCnt - e0); end
    checks++; if (prontoCnt - p0 !== 0) begin errors++; $display("FAIL stoperr_pronto got %0d expected 0", prontoCnt - p0); end
    checks++; if (dado !== 8'h55) begin errors++; $display("FAIL stoperr_dado_held got %h expected 55", dado); end
    checks++; if (dbEstado !== 4'h7) begin errors++; $display("FAIL stoperr_espera got %h expected 7", dbEstado); end
    idle(10);
    checks++; if (dbEstado !== 4'h0) begin errors++; $display("FAIL stoperr_release got %h expected 0", dbEstado); end
    checks++; if (prontoCnt - p0 !== 0) begin errors++; $display("FAIL stoperr_no_frame got %0d expected 0", prontoCnt - p0); end
  endtask

  task automatic test_back_to_back;
    int p0, q0;
    p0 = prontoCnt; q0 = rxQ.size();
    sendFrame(8'hA3, 1'b0, 1'b1);
    sendFrame(8'h0F, 1'b0, 1'b1);
    idle(20);
    checks++; if (prontoCnt - p0 !== 2) begin errors++; $display("FAIL b2b_count got %0d expected 2", prontoCnt - p0); end
    checks++; if (rxQ.size() > q0 && rxQ[q0] !== 8'hA3) begin errors++; $display("FAIL b2b_first got %h expected a3", rxQ[q0]); end
    checks++; if (rxQ.size() > q0 + 1 && rxQ[q0+1] !== 8'h0F) begin errors++; $display("FAIL b2b_second got %h expected 0f", rxQ[q0+1]); end
    checks++; if (dado !== 8'h0F) begin errors++; $display("FAIL b2b_dado got %h expected 0f", dado); end
  endtask

  task automatic test_reset_midframe;
    int p0, e0, q0;
    driveBit(1'b0);
    for (int i = 0; i < 4; i++) driveBit(1'b1);
    rx = 1'b1;
    repeat (200) @(posedge clk); #1;
    checks++; if (dbEstado !== 4'h2) begin errors++; $display("FAIL midrst_in_dados got %h expected 2", dbEstado); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (dado !== 8'h00) begin errors++; $display("FAIL midrst_dado got %h expected 00", dado); end
    checks++; if (dbEstado !== 4'h0) begin errors++; $display("FAIL midrst_dbEstado got %h expected 0", dbEstado); end
    checks++; if (pronto !== 1'b0 || erro_stop !== 1'b0) begin errors++; $display("FAIL midrst_pulses got %b%b expected 00", pronto, erro_stop); end
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    p0 = prontoCnt; e0 = erroCnt; q0 = rxQ.size();
    idle(20);
    sendFrame(8'h3C, 1'b0, 1'b1);
    idle(20);
    checks++; if (prontoCnt - p0 !== 1) begin errors++; $display("FAIL midrst_count got %0d expected 1", prontoCnt - p0); end
    checks++; if (rxQ.size() > q0 && rxQ[q0] !== 8'h3C) begin errors++; $display("FAIL midrst_byte got %h expected 3c", rxQ[q0]); end
    checks++; if (erroCnt - e0 !== 0) begin errors++; $display("FAIL midrst_erro got %0d expected 0", erroCnt - e0); end
  endtask

  task automatic test_parity;
    int p0, r0;
    p0 = prontoCnt; r0 = parCnt;
`ifdef RX_PARIDADE_EN
    // 0x07 has three ones: parity bit 0 is wrong, 1 is right
    sendFrame(8'h07, 1'b0, 1'b1);
    idle(20);
    checks++; if (prontoCnt - p0 !== 1) begin errors++; $display("FAIL par_bad_pronto got %0d expected 1", prontoCnt - p0); end
    checks++; if (dado !== 8'h07) begin errors++; $display("FAIL par_bad_dado got %h expected 07", dado); end
    checks++; if (parCnt - r0 !== 1) begin errors++; $display("FAIL par_bad_flag got %0d expected 1", parCnt - r0); end
    p0 = prontoCnt; r0 = parCnt;
    sendFrame(8'h07, 1'b1, 1'b1);
    idle(20);
    checks++; if (prontoCnt - p0 !== 1) begin errors++; $display("FAIL par_ok_pronto got %0d expected 1", prontoCnt - p0); end
    checks++; if (parCnt - r0 !== 0) begin errors++; $display("FAIL par_ok_flag got %0d expected 0", parCnt - r0); end
`else
    sendFrame(8'h07, 1'b0, 1'b1);
    idle(20);
    checks++; if (prontoCnt - p0 !== 1) begin errors++; $display("FAIL nopar_pronto got %0d expected 1", prontoCnt - p0); end
    checks++; if (dado !== 8'h07) begin errors++; $display("FAIL nopar_dado got %h expected 07", dado); end
    checks++; if (parCnt !== 0) begin errors++; $display("FAIL nopar_flag got %0d expected 0", parCnt); end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    test_reset;
    test_frame_55;
    test_glitch;
    test_stop_error;
    test_back_to_back;
    test_reset_midframe;
    test_parity;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
